// File: rtl/stopwatch_time_counter_pkg.sv
// Shared constants and types for the stopwatch time counter: BCD digit width,
// digit terminal values, reset value and the lap-display state encoding.
package stopwatch_time_counter_pkg;

  localparam int unsigned BCD_W = 4;
  localparam int unsigned NUM_DIGITS = 5;

  localparam logic [BCD_W-1:0] DIGIT_TERM_DEC      = 4'd9;
  localparam logic [BCD_W-1:0] DIGIT_TERM_SEC_TENS = 4'd5;
  localparam logic [BCD_W-1:0] DIGIT_RESET         = 4'd0;

  typedef enum logic {
    LAP_LIVE = 1'b0,
    LAP_HOLD = 1'b1
  } lap_state_e;

  typedef logic [NUM_DIGITS-1:0][BCD_W-1:0] time_digits_t;

endpackage : stopwatch_time_counter_pkg

// File: rtl/stopwatch_time_counter_bcd_digit.sv
// One BCD counter digit that wraps at TERMINAL; advances only when enabled and
// every lower digit is at its terminal value (carry_in).
module bcd_digit
  import stopwatch_time_counter_pkg::*;
#(
  parameter logic [BCD_W-1:0] TERMINAL = DIGIT_TERM_DEC
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic             carry_in,
  output logic [BCD_W-1:0] digit,
  output logic             at_terminal
);

  logic [BCD_W-1:0] digit_q;
  logic [BCD_W-1:0] digit_d;

  assign at_terminal = (digit_q == TERMINAL);
  assign digit       = digit_q;

  // Clear wins over any count so a clear and tick in the same cycle leaves 0.
  always_comb begin
    digit_d = digit_q;
    if (clear) begin
      digit_d = DIGIT_RESET;
    end else if (enable && carry_in) begin
      digit_d = at_terminal ? DIGIT_RESET : digit_q + BCD_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      digit_q <= DIGIT_RESET;
    end else begin
      digit_q <= digit_d;
    end
  end

endmodule : bcd_digit

// File: rtl/stopwatch_time_counter.sv
// BCD M:SS.hh stopwatch counter driven by 10 ms ticks, with a lap register that
// can freeze the display while the live count keeps running.
module stopwatch_time_counter
  import stopwatch_time_counter_pkg::*;
#(
  parameter logic [BCD_W-1:0] MIN_MAX      = 4'd9,
  parameter logic [BCD_W-1:0] SEC_TENS_MAX = DIGIT_TERM_SEC_TENS
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             tick,
  input  logic             clear,
  input  logic             lap,
  output logic [BCD_W-1:0] digit0,
  output logic [BCD_W-1:0] digit1,
  output logic [BCD_W-1:0] digit2,
  output logic [BCD_W-1:0] digit3,
  output logic [BCD_W-1:0] digit4,
  output logic             frozen,
  output logic             overflow,
  output logic             sec_pulse
);

  time_digits_t            live_digits;
  logic [NUM_DIGITS-1:0]   at_term;
  logic [NUM_DIGITS-1:0]   carry;
  logic                    wrap;

  lap_state_e   state_q, state_d;
  time_digits_t lap_q, lap_d;
  logic         overflow_q, overflow_d;
  logic         sec_pulse_q, sec_pulse_d;
  time_digits_t display;

  // carry[n] is high when every digit below n sits at its terminal value.
  assign carry[0] = 1'b1;
  assign carry[1] = at_term[0];
  assign carry[2] = at_term[0] & at_term[1];
  assign carry[3] = carry[2] & at_term[2];
  assign carry[4] = carry[3] & at_term[3];
  assign wrap     = carry[4] & at_term[4];

  bcd_digit #(.TERMINAL(DIGIT_TERM_DEC)) u_hundredths (
    .clock      (clock),
    .reset      (reset),
    .clear      (clear),
    .enable     (tick),
    .carry_in   (carry[0]),
    .digit      (live_digits[0]),
    .at_terminal(at_term[0])
  );

  bcd_digit #(.TERMINAL(DIGIT_TERM_DEC)) u_tenths (
    .clock      (clock),
    .reset      (reset),
    .clear      (clear),
    .enable     (tick),
    .carry_in   (carry[1]),
    .digit      (live_digits[1]),
    .at_terminal(at_term[1])
  );

  bcd_digit #(.TERMINAL(DIGIT_TERM_DEC)) u_sec_units (
    .clock      (clock),
    .reset      (reset),
    .clear      (clear),
    .enable     (tick),
    .carry_in   (carry[2]),
    .digit      (live_digits[2]),
    .at_terminal(at_term[2])
  );

  bcd_digit #(.TERMINAL(SEC_TENS_MAX)) u_sec_tens (
    .clock      (clock),
    .reset      (reset),
    .clear      (clear),
    .enable     (tick),
    .carry_in   (carry[3]),
    .digit      (live_digits[3]),
    .at_terminal(at_term[3])
  );

  bcd_digit #(.TERMINAL(MIN_MAX)) u_minutes (
    .clock      (clock),
    .reset      (reset),
    .clear      (clear),
    .enable     (tick),
    .carry_in   (carry[4]),
    .digit      (live_digits[4]),
    .at_terminal(at_term[4])
  );

  // Lap capture uses the pre-edge live value, so a tick in the same cycle is
  // not included in the held display.
  always_comb begin
    state_d     = state_q;
    lap_d       = lap_q;
    overflow_d  = overflow_q;
    sec_pulse_d = 1'b0;
    if (clear) begin
      state_d    = LAP_LIVE;
      lap_d      = '0;
      overflow_d = 1'b0;
    end else begin
      if (tick && wrap) begin
        overflow_d = 1'b1;
      end
      sec_pulse_d = tick & carry[2];
      if (lap) begin
        case (state_q)
          LAP_LIVE: begin
            state_d = LAP_HOLD;
            lap_d   = live_digits;
          end
          LAP_HOLD: state_d = LAP_LIVE;
          default:  state_d = LAP_LIVE;
        endcase
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= LAP_LIVE;
      lap_q       <= '0;
      overflow_q  <= 1'b0;
      sec_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lap_q       <= lap_d;
      overflow_q  <= overflow_d;
      sec_pulse_q <= sec_pulse_d;
    end
  end

  assign display   = (state_q == LAP_HOLD) ? lap_q : live_digits;
  assign digit0    = display[0];
  assign digit1    = display[1];
  assign digit2    = display[2];
  assign digit3    = display[3];
  assign digit4    = display[4];
  assign frozen    = (state_q == LAP_HOLD);
  assign overflow  = overflow_q;
  assign sec_pulse = sec_pulse_q;

endmodule : stopwatch_time_counter

// File: tb/tb_stopwatch_time_counter.sv
// Directed self-checking bench for stopwatch_time_counter; expected displays
// are hand-computed BCD values packed as {min, sec_tens, sec_units, tenths, hundredths}.
module tb_stopwatch_time_counter;

  logic       clock;
  logic       reset;
  logic       tick;
  logic       clear;
  logic       lap;
  logic [3:0] digit0, digit1, digit2, digit3, digit4;
  logic       frozen;
  logic       overflow;
  logic       sec_pulse;

  int total;
  int bad;
  int secCount;
  bit rangeCheckOn;

  stopwatch_time_counter #(.MIN_MAX(4'd9), .SEC_TENS_MAX(4'd5)) dut (
    .clock    (clock),
    .reset    (reset),
    .tick     (tick),
    .clear    (clear),
    .lap      (lap),
    .digit0   (digit0),
    .digit1   (digit1),
    .digit2   (digit2),
    .digit3   (digit3),
    .digit4   (digit4),
    .frozen   (frozen),
    .overflow (overflow),
    .sec_pulse(sec_pulse)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [19:0] shownTime();
    return {digit4, digit3, digit2, digit1, digit0};
  endfunction

  task automatic checkOutput(input string tag, input logic [19:0] observed,
                             input logic [19:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One clock cycle with the given inputs; returns #1 after the active edge.
  task automatic applyStimulus(input logic t, input logic c, input logic l);
    tick  = t;
    clear = c;
    lap   = l;
    @(posedge clock);
    #1;
    tick  = 1'b0;
    clear = 1'b0;
    lap   = 1'b0;
    if (sec_pulse === 1'b1) secCount++;
  endtask

  task automatic tickRun(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0);
  endtask

  // Every displayed digit stays inside its BCD range whenever reset is released.
  always @(negedge clock) begin
    if (rangeCheckOn && reset === 1'b1) begin
      checkOutput("range_d0", 20'(digit0 <= 4'd9), 20'd1);
      checkOutput("range_d1", 20'(digit1 <= 4'd9), 20'd1);
      checkOutput("range_d2", 20'(digit2 <= 4'd9), 20'd1);
      checkOutput("range_d3", 20'(digit3 <= 4'd5), 20'd1);
      checkOutput("range_d4", 20'(digit4 <= 4'd9), 20'd1);
    end
  end

  initial begin
    total        = 0;
    bad          = 0;
    secCount     = 0;
    rangeCheckOn = 1'b0;
    tick         = 1'b0;
    clear        = 1'b0;
    lap          = 1'b0;
    reset        = 1'b0;

    $display("[TB] reset behaviour");
    #2;
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("reset_display", shownTime(), 20'h00000);
    checkOutput("reset_frozen", 20'(frozen), 20'd0);
    checkOutput("reset_overflow", 20'(overflow), 20'd0);
    checkOutput("reset_sec_pulse", 20'(sec_pulse), 20'd0);
    reset = 1'b1;
    rangeCheckOn = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("post_reset_display", shownTime(), 20'h00000);
    tickRun(1234);
    checkOutput("count_1234", shownTime(), 20'h01234);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async_reset_display", shownTime(), 20'h00000);
    checkOutput("async_reset_frozen", 20'(frozen), 20'd0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;

    $display("[TB] back-to-back ticks");
    secCount = 0;
    tickRun(99);
    checkOutput("count_99", shownTime(), 20'h00099);
    checkOutput("no_pulse_before_100", 20'(sec_pulse), 20'd0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("count_100", shownTime(), 20'h00100);
    checkOutput("pulse_after_100", 20'(sec_pulse), 20'd1);
    checkOutput("pulse_count_100", 20'(secCount), 20'd1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("pulse_single_cycle", 20'(sec_pulse), 20'd0);

    $display("[TB] minute carry and wrap");
    tickRun(5899);
    checkOutput("count_0_59_99", shownTime(), 20'h05999);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("count_1_00_00", shownTime(), 20'h10000);
    checkOutput("pulse_minute", 20'(sec_pulse), 20'd1);
    checkOutput("no_overflow_yet", 20'(overflow), 20'd0);
    tickRun(53999);
    checkOutput("count_9_59_99", shownTime(), 20'h95999);
    checkOutput("no_overflow_at_max", 20'(overflow), 20'd0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("wrap_display", shownTime(), 20'h00000);
    checkOutput("wrap_overflow", 20'(overflow), 20'd1);
    checkOutput("wrap_sec_pulse", 20'(sec_pulse), 20'd1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("wrap_pulse_drop", 20'(sec_pulse), 20'd0);
    checkOutput("overflow_sticky", 20'(overflow), 20'd1);

    $display("[TB] lap hold and release");
    tickRun(307);
    checkOutput("count_3_07", shownTime(), 20'h00307);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("lap_frozen", 20'(frozen), 20'd1);
    checkOutput("lap_display", shownTime(), 20'h00307);
    tickRun(50);
    checkOutput("lap_still_held", shownTime(), 20'h00307);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("lap_release_frozen", 20'(frozen), 20'd0);
    checkOutput("lap_release_display", shownTime(), 20'h00358);

    $display("[TB] clear priority");
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("refreeze", 20'(frozen), 20'd1);
    tickRun(142);
    checkOutput("held_during_run", shownTime(), 20'h00358);
    checkOutput("overflow_before_clear", 20'(overflow), 20'd1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("clear_display", shownTime(), 20'h00000);
    checkOutput("clear_frozen", 20'(frozen), 20'd0);
    checkOutput("clear_overflow", 20'(overflow), 20'd0);
    checkOutput("clear_sec_pulse", 20'(sec_pulse), 20'd0);

    $display("[TB] held tick and gapped ticks");
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("held_tick_7", shownTime(), 20'h00007);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
    end
    checkOutput("gapped_ticks_10", shownTime(), 20'h00010);
    checkOutput("gapped_no_pulse", 20'(sec_pulse), 20'd0);

    rangeCheckOn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_stopwatch_time_counter

// File: doc/stopwatch_time_counter.md
Name: stopwatch_time_counter

Overview:
Downstream consumer of the stopwatch tick pulse generator. Each single-cycle 10 ms tick advances a BCD time count M:SS.hh from 0:00.00 to 9:59.99. A lap register can freeze the displayed value while counting continues. Digit outputs feed the seven-segment display multiplexer.

Parameters:
MIN_MAX, 4'd9, terminal value of the minutes digit (legal range 1..9); minutes wrap MIN_MAX -> 0.
SEC_TENS_MAX, 4'd5, terminal value of the seconds-tens digit; the only supported value is 5.

Ports:
clock  input  1  system clock, rising-edge.
reset  input  1  asynchronous, active-low reset; all state is cleared while low.
tick  input  1  single-cycle count-enable pulse from the pulse generator, one per 10 ms.
clear  input  1  single-cycle synchronous clear (debounced upstream).
lap  input  1  single-cycle lap toggle (debounced upstream).
digit0  output  4  displayed hundredths units, BCD.
digit1  output  4  displayed tenths, BCD.
digit2  output  4  displayed seconds units, BCD.
digit3  output  4  displayed seconds tens, BCD, range 0..5.
digit4  output  4  displayed minutes, BCD, range 0..MIN_MAX.
frozen  output  1  1 while the display shows the lap register.
overflow  output  1  sticky; set when the count wraps past MIN_MAX:59.99.
sec_pulse  output  1  single-cycle pulse registered on the edge where the seconds-units digit increments; drives the colon blink.

Behaviour:
- Reset (reset low, asynchronous): all live digits, all lap digits, frozen, overflow and sec_pulse go to 0. Outputs read 0:00.00 immediately.
- Live counter: five registered BCD digits with moduli 10, 10, 10, 6, MIN_MAX+1.
  - On a clock edge with tick=1 and clear=0, digit0 increments.
  - Each higher digit increments only when every lower digit is at its terminal value (ripple-carry enable, all in the same edge, no extra latency).
  - A digit at its terminal value that receives a carry wraps to 0.
- Latency: tick sampled at edge N updates the digits after edge N. A tick in every consecutive cycle must be handled, with no lost counts.
- Wrap: a tick at MIN_MAX:59.99 sets all digits to 0 and sets overflow=1. overflow stays 1 until clear or reset.
- sec_pulse: 1 for exactly the cycle following the edge on which the digit0/digit1 carry reaches digit2, including the wrap case. Otherwise 0.
- Lap state machine, two states:
  - LIVE (frozen=0): digitN = live digitN.
  - HOLD (frozen=1): digitN = lap register digitN.
  - LIVE + lap=1 -> HOLD; the lap register captures the live value as held in the registers before this edge, i.e. excluding any tick in the same cycle.
  - HOLD + lap=1 -> LIVE; the lap register is unchanged.
  - The live count keeps running in both states.
- clear: has priority over tick and lap in the same cycle. It zeroes live digits and lap digits, clears overflow, forces LIVE, and sec_pulse goes to 0 on the next cycle.
- Outputs are combinational muxes of registered state only; there is no combinational path from any input to any output.
- tick/lap asserted for more than one cycle: each high cycle is a separate event; there is no internal edge detection.

Decomposition:
- Shared package/header: BCD width constant (4), digit terminal constants (9, 5), reset value 4'd0, LIVE/HOLD state encodings.
- Sub-module bcd_digit with parameter TERMINAL, ports clock, reset, clear, enable, carry_in, digit[3:0], at_terminal.
  - Instantiate it five times; the top level chains at_terminal into the carry enables.
- Lap register, state machine and output mux live in the top level.

Test Plan:
1. Hold reset low, pulse tick, release reset -> all digits 0, frozen=0, overflow=0. Drive reset low asynchronously mid-count at 0:12.34 -> outputs 0:00.00 without waiting for a clock edge.
2. Issue 100 ticks, one per cycle, back-to-back -> display 0:01.00. sec_pulse seen exactly once, on the cycle after the 100th tick.
3. Preload to 0:59.99 via ticks, one more tick -> 1:00.00. Preload to 9:59.99, one tick -> 0:00.00, overflow=1, sec_pulse=1 for one cycle.
4. At live 0:03.07, assert lap together with tick -> frozen=1, display 0:03.07, live 0:03.08. After 50 more ticks the display is still 0:03.07. Lap again -> frozen=0, display 0:03.58.
5. With frozen=1, overflow=1, live 0:05.00, assert clear, tick and lap together -> next cycle live 0:00.00, display 0:00.00, frozen=0, overflow=0.
6. Keep tick held high for 7 cycles, then give 3 ticks with idle gaps -> display 0:00.10. No digit ever leaves its BCD range (assertion: digit3<=5, digit4<=MIN_MAX, others<=9).
